seq_shift_unit: RTL and testbench

Parametrised multi-cycle shift/rotate unit, the successor to the single-step shift register. Loads a w-bit operand, then on a start handshake shifts or rotates it by a runtime amount, one position per clock. Five modes: logical right, arithmetic right, logical left, rotate right and rotate left. Exposes busy/done status and the last bit shifted out, for use as a datapath helper beside the ALU and counters.

---
 rtl/seq_shift_pkg.sv | 21 ++
 rtl/seq_shift_if.sv | 23 ++
 rtl/seq_shift_step.sv | 34 +++
 rtl/seq_shift_unit.sv | 93 +++++++++
 tb/tb_seq_shift_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_shift_pkg : mode and state encodings for the sequential shifter |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package seq_shift_pkg;

  localparam logic [2:0] MODE_LSR = 3'b000;
  localparam logic [2:0] MODE_ASR = 3'b001;
  localparam logic [2:0] MODE_LSL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_shift_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_shift_if : control/data bundle between a client and the shifter |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface seq_shift_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic          ld;
  logic [W-1:0]  d;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic          so;
  logic          busy;
  logic          done;

  modport master (output ld, d, start, mode, amt, input  q, so, busy, done);
  modport slave  (input  ld, d, start, mode, amt, output q, so, busy, done);
endinterface
`default_nettype wire

// File: rtl/seq_shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_shift_step : one-position shift/rotate of an operand (comb.)    |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module seq_shift_step
  import seq_shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_q,
  input  logic [2:0]   i_mode,
  output logic [W-1:0] o_next_q,
  output logic         o_out_bit,
  output logic         o_active
);

  // o_active low marks the hold encodings, so the caller keeps q and so.
  always_comb begin
    o_next_q  = i_q;
    o_out_bit = 1'b0;
    o_active  = 1'b1;
    case (i_mode)
      MODE_LSR: begin o_next_q = {1'b0, i_q[W-1:1]};        o_out_bit = i_q[0];   end
      MODE_ASR: begin o_next_q = {i_q[W-1], i_q[W-1:1]};    o_out_bit = i_q[0];   end
      MODE_LSL: begin o_next_q = {i_q[W-2:0], 1'b0};        o_out_bit = i_q[W-1]; end
      MODE_ROR: begin o_next_q = {i_q[0], i_q[W-1:1]};      o_out_bit = i_q[0];   end
      MODE_ROL: begin o_next_q = {i_q[W-2:0], i_q[W-1]};    o_out_bit = i_q[W-1]; end
      default:  o_active = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_shift_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_shift_unit : multi-cycle shift/rotate by a runtime amount       |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int              W       = 8,
  parameter int              AW      = 4,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  wire logic  clk,
  input  wire logic  rst_b,
  seq_shift_if.slave bus
);

  localparam logic [AW-1:0] c_CNT_ZERO = '0;
  localparam logic [AW-1:0] c_CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_q;
  logic          r_so;
  logic [AW-1:0] r_cnt;
  logic [2:0]    r_mode;

  logic [W-1:0]  w_step_q;
  logic          w_step_bit;
  logic          w_step_act;

  seq_shift_step #(.W(W)) u_step (
    .i_q      (r_q),
    .i_mode   (r_mode),
    .o_next_q (w_step_q),
    .o_out_bit(w_step_bit),
    .o_active (w_step_act)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!bus.ld && bus.start)
          w_next_state = (bus.amt == c_CNT_ZERO) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: if (r_cnt == c_CNT_ONE) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Hold modes still burn one count per cycle; only q/so stay put.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_q    <= RST_VAL;
      r_so   <= 1'b0;
      r_cnt  <= c_CNT_ZERO;
      r_mode <= MODE_LSR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ld) begin
            r_q <= bus.d;
          end else if (bus.start) begin
            r_mode <= bus.mode;
            r_cnt  <= bus.amt;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (w_step_act) begin
            r_q  <= w_step_q;
            r_so <= w_step_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.so   = r_so;
  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_shift_unit : scoreboard bench for seq_shift_unit (w=8, w=4)  |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_seq_shift_unit;
  import seq_shift_pkg::*;

  logic clk = 1'b0;
  logic rst8_b = 1'b1;
  logic rst4_b = 1'b1;
  always #5 clk = ~clk;

  seq_shift_if #(.W(8), .AW(4)) bus8 ();
  seq_shift_if #(.W(4), .AW(4)) bus4 ();

  seq_shift_unit #(.W(8), .AW(4), .RST_VAL(8'hA5)) dut8 (.clk(clk), .rst_b(rst8_b), .bus(bus8));
  seq_shift_unit #(.W(4), .AW(4), .RST_VAL(4'h3))  dut4 (.clk(clk), .rst_b(rst4_b), .bus(bus4));

  typedef struct {
    logic [7:0] q;
    logic       so;
    int         nbusy;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;
  int   checks = 0;
  int   errors = 0;
  int   busy8 = 0;
  int   busy4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst8_b) busy8 = 0;
    else begin
      if (bus8.busy) busy8++;
      if (bus8.done) begin
        if (sb8.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut8_unexpected_done: got done=1 expected none (q=%0h)", bus8.q);
        end else begin
          e8 = sb8.pop_front();
          chk("dut8_q", {24'd0, bus8.q}, {24'd0, e8.q});
          chk("dut8_so", {31'd0, bus8.so}, {31'd0, e8.so});
          chk("dut8_busy_cycles", busy8, e8.nbusy);
        end
        busy8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4_b) busy4 = 0;
    else begin
      if (bus4.busy) busy4++;
      if (bus4.done) begin
        if (sb4.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut4_unexpected_done: got done=1 expected none (q=%0h)", bus4.q);
        end else begin
          e4 = sb4.pop_front();
          chk("dut4_q", {28'd0, bus4.q}, {24'd0, e4.q});
          chk("dut4_so", {31'd0, bus4.so}, {31'd0, e4.so});
          chk("dut4_busy_cycles", busy4, e4.nbusy);
        end
        busy4 = 0;
      end
    end
  end

  task automatic ld8(input logic [7:0] v);
    bus8.ld = 1'b1; bus8.d = v;
    @(posedge clk); #1;
    bus8.ld = 1'b0;
    chk("dut8_ld_q", {24'd0, bus8.q}, {24'd0, v});
  endtask

  task automatic op8(input logic [2:0] m, input logic [3:0] a,
                     input logic [7:0] eq, input logic eso, input int nb);
    sb8.push_back('{eq, eso, nb});
    bus8.start = 1'b1; bus8.mode = m; bus8.amt = a;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (int'(a) + 1) @(posedge clk);
    #1;
    chk("dut8_idle_after", {30'd0, bus8.busy, bus8.done}, 32'd0);
  endtask

  task automatic op4(input logic [2:0] m, input logic [3:0] a,
                     input logic [3:0] eq, input logic eso, input int nb);
    sb4.push_back('{{4'd0, eq}, eso, nb});
    bus4.start = 1'b1; bus4.mode = m; bus4.amt = a;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (int'(a) + 1) @(posedge clk);
    #1;
    chk("dut4_idle_after", {30'd0, bus4.busy, bus4.done}, 32'd0);
  endtask

  initial begin
    bus8.ld = 1'b0; bus8.d = '0; bus8.start = 1'b0; bus8.mode = MODE_LSR; bus8.amt = '0;
    bus4.ld = 1'b0; bus4.d = '0; bus4.start = 1'b0; bus4.mode = MODE_LSR; bus4.amt = '0;

    // Asynchronous reset between clock edges.
    #2 rst8_b = 1'b0; rst4_b = 1'b0;
    #1;
    chk("rst_q", {24'd0, bus8.q}, 32'hA5);
    chk("rst_so", {31'd0, bus8.so}, 32'd0);
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done", {31'd0, bus8.done}, 32'd0);
    chk("rst4_q", {28'd0, bus4.q}, 32'h3);
    #4 rst8_b = 1'b1; rst4_b = 1'b1;
    @(posedge clk); #1;

    ld8(8'b1001_0110);
    op8(MODE_ASR, 4'd3, 8'b1111_0010, 1'b1, 3);
    ld8(8'b1001_0110);
    op8(MODE_LSR, 4'd3, 8'b0001_0010, 1'b1, 3);
    ld8(8'h81);
    op8(MODE_ROL, 4'd9, 8'h03, 1'b1, 9);
    ld8(8'h5A);
    op8(MODE_LSR, 4'd0, 8'h5A, 1'b1, 0);
    ld8(8'hFF);
    op8(MODE_LSL, 4'd10, 8'h00, 1'b0, 10);

    // ld and start together: load wins, no operation.
    bus8.ld = 1'b1; bus8.d = 8'h3C; bus8.start = 1'b1; bus8.mode = MODE_LSR; bus8.amt = 4'd2;
    @(posedge clk); #1;
    bus8.ld = 1'b0; bus8.start = 1'b0;
    chk("ldstart_q", {24'd0, bus8.q}, 32'h3C);
    repeat (4) @(posedge clk);
    #1;
    chk("ldstart_no_op", {24'd0, bus8.q}, 32'h3C);

    // Inputs toggled mid-operation are ignored.
    ld8(8'b1001_0110);
    sb8.push_back('{8'hB0, 1'b0, 3});
    bus8.start = 1'b1; bus8.mode = MODE_LSL; bus8.amt = 4'd3;
    @(posedge clk); #1;
    bus8.ld = 1'b1; bus8.d = 8'hFF; bus8.start = 1'b1; bus8.mode = MODE_ROR; bus8.amt = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    bus8.ld = 1'b0; bus8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("toggle_idle_q", {24'd0, bus8.q}, 32'hB0);

    op8(3'b110, 4'd2, 8'hB0, 1'b0, 2);
    ld8(8'h81);
    op8(MODE_ROR, 4'd1, 8'hC0, 1'b1, 1);

    // w=4: reset in the middle of an amt=7 rotate aborts it.
    bus4.start = 1'b1; bus4.mode = MODE_ROL; bus4.amt = 4'd7;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst4_b = 1'b0;
    #1;
    chk("rst4_mid_q", {28'd0, bus4.q}, 32'h3);
    chk("rst4_mid_busy", {31'd0, bus4.busy}, 32'd0);
    chk("rst4_mid_done", {31'd0, bus4.done}, 32'd0);
    #2 rst4_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    op4(MODE_LSR, 4'd1, 4'h1, 1'b1, 1);
    op4(MODE_ROL, 4'd5, 4'h2, 1'b0, 5);

    chk("sb8_drained", sb8.size(), 32'd0);
    chk("sb4_drained", sb4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
